// File: rtl/fifo16_ctrl.sv
// ---------------------------------------------------------------------------
// fifo16_ctrl
//
// 16-word synchronous FIFO controller with first-word-fall-through output.
// The storage is a 16 x DATA_W array with synchronous write and asynchronous
// read. It maps onto DATA_W 16x1 simple-dual-port distributed-RAM slices that
// share one write address and one read address.
//
// Parameters
//   DATA_W    data width in bits (1..32)
//   AF_LEVEL  ALMOST_FULL asserts when COUNT >= AF_LEVEL (1..16)
//   AE_LEVEL  ALMOST_EMPTY asserts when COUNT <= AE_LEVEL (0..15)
//
// Ports
//   CLK           in   clock; all state changes on its rising edge
//   RESETN        in   asynchronous active-low reset
//   WR_EN         in   write request
//   DI            in   write data [DATA_W]
//   RD_EN         in   read request; pops the word currently on DO
//   DO            out  head-of-FIFO word, valid in the same cycle (show-ahead)
//   EMPTY         out  FIFO holds 0 words
//   FULL          out  FIFO holds 16 words
//   ALMOST_FULL   out  COUNT >= AF_LEVEL
//   ALMOST_EMPTY  out  COUNT <= AE_LEVEL
//   COUNT         out  words stored, 0..16 [5]
//   OVERFLOW      out  one-cycle pulse after a rejected write
//   UNDERFLOW     out  one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module fifo16_ctrl #(
    parameter int DATA_W   = 8,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] DI,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] DO,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [4:0]        COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam logic [4:0] DEPTH    = 5'd16;
    localparam logic [4:0] AF_LVL   = 5'(AF_LEVEL);
    localparam logic [4:0] AE_LVL   = 5'(AE_LEVEL);

    // Storage: never reset, so it can live in LUT RAM.
    logic [DATA_W-1:0] mem [16];

    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;

    logic       wr_accept;
    logic       rd_accept;
    logic       wr_reject;
    logic       rd_reject;
    logic [4:0] count_next;

    // -----------------------------------------------------------------------
    // Request qualification.
    // A write is still accepted while FULL when a read pops the head in the
    // same cycle: the freed slot is the one the write pointer already points
    // at. A read while EMPTY is always rejected, even with a concurrent write,
    // because the head does not yet exist on DO.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_accept = WR_EN & (~FULL | RD_EN);
        rd_accept = RD_EN & ~EMPTY;
        wr_reject = WR_EN & FULL & ~RD_EN;
        rd_reject = RD_EN & EMPTY;
    end

    // Next occupancy. Flags are registered from this value so they always
    // agree with COUNT in the same cycle.
    always_comb begin
        count_next = COUNT;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = COUNT + 5'd1;
            2'b01:   count_next = COUNT - 5'd1;
            default: count_next = COUNT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Array: synchronous write, asynchronous read at the read pointer.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr] <= DI;
        end
    end

    assign DO = mem[rd_ptr];

    // -----------------------------------------------------------------------
    // Pointers: 4-bit, wrap 15 -> 0 naturally.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy, status flags and error pulses.
    // ALMOST_EMPTY resets high because COUNT=0 always satisfies 0 <= AE_LEVEL.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            COUNT        <= 5'd0;
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            COUNT        <= count_next;
            EMPTY        <= (count_next == 5'd0);
            FULL         <= (count_next == DEPTH);
            ALMOST_FULL  <= (count_next >= AF_LVL);
            ALMOST_EMPTY <= (count_next <= AE_LVL);
            // Re-evaluated every cycle, so back-to-back rejects keep it high.
            OVERFLOW     <= wr_reject;
            UNDERFLOW    <= rd_reject;
        end
    end

endmodule

// File: tb/tb_fifo16_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo16_ctrl
//
// Directed sequence followed by randomized traffic, compared against a
// queue-based reference model of a 16-entry FWFT FIFO.
// ---------------------------------------------------------------------------
module tb_fifo16_ctrl;

    localparam int DW = 8;
    localparam int AF = 12;
    localparam int AE = 4;

    logic          CLK;
    logic          RESETN;
    logic          WR_EN;
    logic          RD_EN;
    logic [DW-1:0] DI;
    logic [DW-1:0] DO;
    logic          EMPTY;
    logic          FULL;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic [4:0]    COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          exp_ovf;
    logic          exp_unf;

    fifo16_ctrl #(
        .DATA_W   (DW),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .WR_EN        (WR_EN),
        .DI           (DI),
        .RD_EN        (RD_EN),
        .DO           (DO),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"}, 32'(COUNT), 32'(sz));
        chk({tag, ".empty"}, 32'(EMPTY), 32'(sz == 0));
        chk({tag, ".full"},  32'(FULL),  32'(sz == 16));
        chk({tag, ".afull"}, 32'(ALMOST_FULL),  32'(sz >= AF));
        chk({tag, ".aempty"},32'(ALMOST_EMPTY), 32'(sz <= AE));
        chk({tag, ".ovf"},   32'(OVERFLOW),  32'(exp_ovf));
        chk({tag, ".unf"},   32'(UNDERFLOW), 32'(exp_unf));
        if (sz != 0) begin
            chk({tag, ".do"}, 32'(DO), 32'(q[0]));
        end
    endtask

    // Apply one request cycle, advance the model at the edge, check at negedge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        logic was_full;
        logic was_empty;
        WR_EN = w;
        RD_EN = r;
        DI    = d;
        @(posedge CLK);
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (r && !was_empty) void'(q.pop_front());
        if (w && (!was_full || r)) q.push_back(d);
        exp_ovf = w && was_full && !r;
        exp_unf = r && was_empty;
        @(negedge CLK);
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        check_state(tag);
    endtask

    // Drop RESETN between edges and check flags before the next rising edge.
    task automatic async_reset(input string tag);
        #2;
        RESETN = 1'b0;
        #1;
        q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_state(tag);
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        DI      = '0;
        RESETN  = 1'b1;

        // Power-on reset, released on a falling edge
        #2;
        RESETN = 1'b0;
        #1;
        check_state("rst_init");
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;

        // Idle 4 cycles
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, "idle");
        chk("idle.empty_const", 32'(EMPTY), 32'd1);
        chk("idle.count_const", 32'(COUNT), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, DW'(i + 1), "fill");
            if (i == 10) chk("fill.af_after11", 32'(ALMOST_FULL), 32'd0);
            if (i == 11) chk("fill.af_after12", 32'(ALMOST_FULL), 32'd1);
        end
        chk("fill.full_const",  32'(FULL),  32'd1);
        chk("fill.count_const", 32'(COUNT), 32'd16);

        // Overflow attempt, then pulse must drop
        cycle(1'b1, 1'b0, 8'hAA, "ovf");
        chk("ovf.pulse", 32'(OVERFLOW), 32'd1);
        cycle(1'b0, 1'b0, '0, "ovf_end");
        chk("ovf.cleared", 32'(OVERFLOW), 32'd0);

        // Drain, checking the show-ahead word before each pop
        for (int i = 0; i < 16; i++) begin
            chk("drain.do_const", 32'(DO), 32'(i + 1));
            cycle(1'b0, 1'b1, '0, "drain");
        end
        chk("drain.empty_const", 32'(EMPTY), 32'd1);
        cycle(1'b0, 1'b1, '0, "unf");
        chk("unf.pulse", 32'(UNDERFLOW), 32'd1);
        cycle(1'b0, 1'b1, '0, "unf2");
        chk("unf.consecutive", 32'(UNDERFLOW), 32'd1);
        cycle(1'b0, 1'b0, '0, "unf_end");

        // Pointer wrap
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i), "wrap_w1");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "wrap_r1");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(8'h20 + i), "wrap_w2");
        for (int i = 0; i < 10; i++) begin
            chk("wrap.do_const", 32'(DO), 32'(8'h20 + i));
            cycle(1'b0, 1'b1, '0, "wrap_r2");
        end
        chk("wrap.count_const", 32'(COUNT), 32'd0);

        // Empty with simultaneous write+read: write only
        cycle(1'b1, 1'b1, 8'h66, "empty_wr_rd");
        chk("empty_wr_rd.unf", 32'(UNDERFLOW), 32'd1);
        chk("empty_wr_rd.do",  32'(DO), 32'h66);
        cycle(1'b0, 1'b1, '0, "empty_wr_rd_pop");

        // Full with simultaneous write+read
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(8'h30 + i), "fill2");
        cycle(1'b1, 1'b1, 8'h55, "full_wr_rd");
        chk("full_wr_rd.count", 32'(COUNT), 32'd16);
        chk("full_wr_rd.ovf",   32'(OVERFLOW), 32'd0);
        chk("full_wr_rd.head",  32'(DO), 32'h31);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, "fr_drain");
        chk("full_wr_rd.tail", 32'(DO), 32'h55);
        cycle(1'b0, 1'b1, '0, "fr_last");

        // Mid-operation reset
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), "pre_rst");
        async_reset("mid_rst");
        chk("mid_rst.count_const", 32'(COUNT), 32'd0);
        cycle(1'b1, 1'b0, 8'h77, "post_rst_w");
        chk("post_rst.do", 32'(DO), 32'h77);
        cycle(1'b0, 1'b1, '0, "post_rst_r");
        chk("post_rst.empty", 32'(EMPTY), 32'd1);

        // Randomized traffic in phases biased toward full, empty and mixed
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            int pr;
            case (ph)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 20; pr = 80; end
                2:       begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 95; end
            endcase
            for (int i = 0; i < 400; i++) begin
                logic w;
                logic r;
                w = ($urandom_range(99) < 32'(pw));
                r = ($urandom_range(99) < 32'(pr));
                cycle(w, r, DW'($urandom), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo16_ctrl.md
FIFO16_CTRL -- requirements
Module: fifo16_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (1..32).
REQ-002 SHALL have parameter AF_LEVEL, default 12, ALMOST_FULL threshold in words (1..16).
REQ-003 SHALL have parameter AE_LEVEL, default 4, ALMOST_EMPTY threshold in words (0..15).
REQ-004 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 RESETN  input  1  asynchronous, active-low reset.
REQ-006 WR_EN  input  1  write request.
REQ-007 DI  input  DATA_W  write data.
REQ-008 RD_EN  input  1  read request; pops the word currently on DO.
REQ-009 DO  output  DATA_W  head-of-FIFO data, show-ahead.
REQ-010 EMPTY  output  1  FIFO holds 0 words.
REQ-011 FULL  output  1  FIFO holds 16 words.
REQ-012 ALMOST_FULL  output  1  COUNT >= AF_LEVEL.
REQ-013 ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL.
REQ-014 COUNT  output  5  words stored, 0..16.
REQ-015 OVERFLOW  output  1  one-cycle pulse: write rejected.
REQ-016 UNDERFLOW  output  1  one-cycle pulse: read rejected.

Function
REQ-017 Storage SHALL be a 16 x DATA_W array with synchronous write and asynchronous read, i.e. DATA_W 16x1 SDP distributed-RAM bit slices sharing write and read addresses.
REQ-018 Write pointer and read pointer SHALL be 4 bits and wrap 15 -> 0 without gaps.
REQ-019 Write accepted = WR_EN & (~FULL | RD_EN); accepted write stores DI at write pointer and increments it at the same edge.
REQ-020 Read accepted = RD_EN & ~EMPTY; accepted read increments read pointer.
REQ-021 DO SHALL combinationally present the array word at the read pointer, zero-cycle latency (first-word-fall-through); DO is don't-care while EMPTY=1.
REQ-022 A word written at edge N SHALL appear on DO after edge N when the FIFO was empty before edge N; EMPTY deasserts after edge N.
REQ-023 COUNT SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY SHALL be registered and consistent with COUNT in the same cycle (EMPTY = COUNT==0, FULL = COUNT==16).
REQ-025 When FULL, WR_EN & RD_EN together SHALL accept both; the head is popped and DI written into the freed slot; COUNT stays 16.
REQ-026 When EMPTY, WR_EN & RD_EN together SHALL accept the write only; the read is rejected.
REQ-027 WR_EN while FULL without RD_EN SHALL be ignored (no pointer, array or COUNT change) and pulse OVERFLOW for exactly the next cycle.
REQ-028 RD_EN while EMPTY SHALL be ignored and pulse UNDERFLOW for exactly the next cycle.
REQ-029 OVERFLOW and UNDERFLOW SHALL be registered, high one cycle per rejected request, and high consecutively for consecutive rejected requests.

Reset
REQ-030 RESETN low SHALL immediately force both pointers to 0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, regardless of CLK.
REQ-031 The array SHALL NOT be reset; its contents are don't-care after reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; the first write after release SHALL be the first word read.
REQ-033 Requests on the first rising edge after RESETN deasserts SHALL be honoured normally.

Verification
REQ-034 Reset, then idle 4 cycles -> EMPTY=1, COUNT=0, ALMOST_EMPTY=1, all pulses 0.
REQ-035 Write 0x01..0x10 on 16 consecutive cycles -> COUNT=16, FULL=1, ALMOST_FULL set after the 12th write; 17th write 0xAA -> OVERFLOW one cycle, COUNT stays 16.
REQ-036 From full, read 16 times -> DO sequence 0x01..0x10, EMPTY=1 after the last; one further read -> UNDERFLOW one cycle.
REQ-037 Wrap: write 10, read 10, write 10 with values 0x20..0x29, read 10 -> DO sequence 0x20..0x29, COUNT returns to 0.
REQ-038 At FULL, WR_EN=RD_EN=1 with DI=0x55 for 1 cycle -> old head popped, COUNT=16; after 15 reads DO=0x55.
REQ-039 8 words stored, RESETN pulsed low mid-cycle -> flags reset immediately; write 0x77 then read -> DO=0x77.
